// File: rtl/data_mem_arbiter_if.sv
// data_mem_arbiter_if
// Bundles the two requester ports and the single-port memory bus that sit
// around data_mem_arbiter.
//   slave  : the arbiter's view (takes requests and memory read data; drives
//            grants, responses and the memory control/address/data bus).
//   master : the environment's view (requesters plus the memory itself).
// Per requester n (0 = core load/store, 1 = debug/loader):
//   reqn, wen, sizen[1:0], unsn, addrn[31:0], wdatan[31:0] : request fields
//   gntn, rvalidn, rdatan[31:0], errn                       : grant / response
// Memory side:
//   mem_cs (active-low), mem_rd_wr (1 = read), mem_mask[3:0],
//   mem_addr[31:0], mem_wdata[31:0], mem_rdata[31:0] (combinational read)
interface data_mem_arbiter_if;
    logic        req0;
    logic        req1;
    logic        we0;
    logic        we1;
    logic [1:0]  size0;
    logic [1:0]  size1;
    logic        uns0;
    logic        uns1;
    logic [31:0] addr0;
    logic [31:0] addr1;
    logic [31:0] wdata0;
    logic [31:0] wdata1;

    logic        gnt0;
    logic        gnt1;
    logic        rvalid0;
    logic        rvalid1;
    logic [31:0] rdata0;
    logic [31:0] rdata1;
    logic        err0;
    logic        err1;

    logic        mem_cs;
    logic        mem_rd_wr;
    logic [3:0]  mem_mask;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  req0, req1, we0, we1, size0, size1, uns0, uns1,
               addr0, addr1, wdata0, wdata1, mem_rdata,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1,
               mem_cs, mem_rd_wr, mem_mask, mem_addr, mem_wdata
    );

    modport master (
        output req0, req1, we0, we1, size0, size1, uns0, uns1,
               addr0, addr1, wdata0, wdata1, mem_rdata,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1,
               mem_cs, mem_rd_wr, mem_mask, mem_addr, mem_wdata
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
// Shares one single-port data memory between the core load/store path
// (port 0) and a debug/loader port (port 1) with round-robin arbitration.
// Every accepted request becomes one memory cycle (ACCESS) followed by a
// one-cycle response (RESP) to the winning port. A new request may be
// granted during RESP, giving one access every two cycles.
// Ports:
//   clk   : clock (memory writes land on its falling edge)
//   rst_n : asynchronous active-low reset
//   bus   : data_mem_arbiter_if.slave - requests, responses, memory bus
module data_mem_arbiter (
    input  logic                clk,
    input  logic                rst_n,
    data_mem_arbiter_if.slave   bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    logic [1:0]  state_reg;
    logic [1:0]  state_next;
    logic        last_reg;     // port that won the most recent grant
    logic        port_reg;     // owner of the access in flight
    logic        we_reg;
    logic [1:0]  size_reg;
    logic        uns_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [31:0] rdata_reg;
    logic        err_reg;

    logic        grant_window;
    logic        gnt0;
    logic        gnt1;
    logic        accept;
    logic        illegal;
    logic        active;
    logic [3:0]  store_mask;
    logic [7:0]  lane_data [4];
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_ext;

    // ------------------------------------------------------------------
    // Arbitration. Grants are only offered when the memory is free for the
    // next cycle, and are held low throughout reset. On a tie the port that
    // did not win last time gets the grant.
    // ------------------------------------------------------------------
    assign grant_window = rst_n && (state_reg == IDLE || state_reg == RESP);
    assign gnt0   = grant_window && bus.req0 && (!bus.req1 || last_reg);
    assign gnt1   = grant_window && bus.req1 && (!bus.req0 || !last_reg);
    assign accept = gnt0 || gnt1;

    assign bus.gnt0 = gnt0;
    assign bus.gnt1 = gnt1;

    always_comb begin
        state_next = IDLE;
        case (state_reg)
            IDLE:    state_next = accept ? ACCESS : IDLE;
            ACCESS:  state_next = RESP;
            RESP:    state_next = accept ? ACCESS : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Request decode on the latched fields
    // ------------------------------------------------------------------
    assign illegal = (size_reg == 2'b11)
                  || (size_reg == 2'b01 && addr_reg[0])
                  || (size_reg == 2'b10 && addr_reg[1:0] != 2'b00);

    // Illegal requests still spend a cycle in ACCESS but never touch memory.
    assign active = (state_reg == ACCESS) && !illegal;

    // Per-lane write enable and replicated store data.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign store_mask[gi] = (size_reg == 2'b00 && addr_reg[1:0] == 2'(gi))
                                 || (size_reg == 2'b01 && addr_reg[1] == 1'(gi / 2))
                                 || (size_reg == 2'b10);
            assign lane_data[gi]  = (size_reg == 2'b00) ? wdata_reg[7:0] :
                                    (size_reg == 2'b01) ? wdata_reg[8*(gi%2) +: 8] :
                                                          wdata_reg[8*gi +: 8];
        end
    endgenerate

    // Memory bus parks at read / deselected / zero outside a legal access.
    assign bus.mem_cs    = !active;
    assign bus.mem_rd_wr = active ? !we_reg : 1'b1;
    assign bus.mem_mask  = (active && we_reg) ? store_mask : 4'b0000;
    assign bus.mem_addr  = active ? {addr_reg[31:2], 2'b00} : 32'd0;
    assign bus.mem_wdata = active ? {lane_data[3], lane_data[2], lane_data[1], lane_data[0]}
                                  : 32'd0;

    // ------------------------------------------------------------------
    // Load alignment and extension from the combinational read data
    // ------------------------------------------------------------------
    always_comb begin
        load_byte = bus.mem_rdata[{addr_reg[1:0], 3'b000} +: 8];
        load_half = addr_reg[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        case (size_reg)
            2'b00:   load_ext = {{24{!uns_reg && load_byte[7]}}, load_byte};
            2'b01:   load_ext = {{16{!uns_reg && load_half[15]}}, load_half};
            default: load_ext = bus.mem_rdata;
        endcase
    end

    // ------------------------------------------------------------------
    // State and request registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            last_reg  <= 1'b1;
            port_reg  <= 1'b0;
            we_reg    <= 1'b0;
            size_reg  <= 2'b00;
            uns_reg   <= 1'b0;
            addr_reg  <= 32'd0;
            wdata_reg <= 32'd0;
            rdata_reg <= 32'd0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                port_reg  <= gnt1;
                last_reg  <= gnt1;
                we_reg    <= gnt1 ? bus.we1    : bus.we0;
                size_reg  <= gnt1 ? bus.size1  : bus.size0;
                uns_reg   <= gnt1 ? bus.uns1   : bus.uns0;
                addr_reg  <= gnt1 ? bus.addr1  : bus.addr0;
                wdata_reg <= gnt1 ? bus.wdata1 : bus.wdata0;
            end
            // Response is captured at the edge that ends ACCESS.
            if (state_reg == ACCESS) begin
                err_reg   <= illegal;
                rdata_reg <= (illegal || we_reg) ? 32'd0 : load_ext;
            end
        end
    end

    // ------------------------------------------------------------------
    // Responses: only the owning port sees anything during RESP.
    // ------------------------------------------------------------------
    assign bus.rvalid0 = (state_reg == RESP) && !port_reg;
    assign bus.rvalid1 = (state_reg == RESP) &&  port_reg;
    assign bus.rdata0  = bus.rvalid0 ? rdata_reg : 32'd0;
    assign bus.rdata1  = bus.rvalid1 ? rdata_reg : 32'd0;
    assign bus.err0    = bus.rvalid0 && err_reg;
    assign bus.err1    = bus.rvalid1 && err_reg;
endmodule
